// File: rtl/stack_reverser.sv
// Stream reverser that drives an external LIFO: fills it with up to STACK_DEPTH
// beats of a packet, then pops them back out as a reversed valid/ready stream.
module stack_reverser #(
  parameter int DATA_WIDTH  = 3,
  parameter int STACK_DEPTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic                  stk_read_more,
  output logic [DATA_WIDTH-1:0] stk_data_in,
  input  logic [DATA_WIDTH-1:0] stk_data_out,
  input  logic                  stk_full,
  input  logic                  stk_empty,
  input  logic                  stk_error,
  output logic                  seg_split,
  output logic                  err
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);

  typedef enum logic [1:0] {FILL, POP, CAPT, HOLD} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_seg_last;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_seg_split;
  logic                  r_err;

  logic w_accept;
  logic w_pop_bad;

  // NOTE: the strobes are gated with rst so nothing reaches the stack while
  // reset is held, even though the FSM already sits in FILL.
  assign in_ready  = rst && (r_state == FILL) && !stk_full && (r_cnt < DEPTH_C);
  assign w_accept  = in_valid && in_ready;
  assign w_pop_bad = (r_state == POP) && stk_empty && (r_cnt != '0);
  assign stk_push  = w_accept;
  assign stk_pop   = rst && (r_state == POP) && !w_pop_bad;

  assign stk_read_more = 1'b0;
  assign stk_data_in   = in_data;
  assign out_valid     = r_out_valid;
  assign out_last      = r_out_last;
  assign out_data      = r_out_data;
  assign seg_split     = r_seg_split;
  assign err           = r_err;

  // NOTE: all state updates use non-blocking assignments so every branch sees
  // the pre-edge values of r_cnt and r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_seg_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_seg_split <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_seg_split <= 1'b0;
      if (stk_error) r_err <= 1'b1;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
            if (in_last) begin
              r_seg_last <= 1'b1;
              r_state    <= POP;
            end else if (r_cnt + CW'(1) == DEPTH_C) begin
              r_seg_last  <= 1'b0;
              r_seg_split <= 1'b1;
              r_state     <= POP;
            end
          end
        end
        POP: begin
          // Stack claims empty while we still count words: resync and carry on.
          if (w_pop_bad) begin
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= FILL;
          end else begin
            r_cnt   <= r_cnt - CW'(1);
            r_state <= CAPT;
          end
        end
        CAPT: begin
          r_out_data  <= stk_data_out;
          r_out_valid <= 1'b1;
          r_out_last  <= r_seg_last && (r_cnt == '0);
          r_state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_state     <= (r_cnt != '0) ? POP : FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_reverser.sv
// Bench for stack_reverser: behavioural LIFO model on the stack side and a
// scoreboard of reversed beats checked at each output handshake.
module tb_stack_reverser;

  localparam int DW = 3;
  localparam int D  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_last, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_last, out_ready;
  logic [DW-1:0] out_data;
  logic          stk_push, stk_pop, stk_read_more;
  logic [DW-1:0] stk_data_in, stk_data_out;
  logic          stk_full, stk_empty, stk_error;
  logic          seg_split, err;

  logic          force_empty;
  logic          tb_err;

  always #5 clk = ~clk;

  stack_reverser #(.DATA_WIDTH(DW), .STACK_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .out_ready(out_ready),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_read_more(stk_read_more),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_error(stk_error),
    .seg_split(seg_split), .err(err)
  );

  // LIFO model of the attached stack, reset by the same rst.
  logic [DW-1:0] m_mem [D];
  int            m_cnt;
  logic [DW-1:0] m_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt  <= 0;
      m_dout <= '0;
    end else if (stk_push && m_cnt < D) begin
      m_mem[m_cnt] <= stk_data_in;
      m_cnt        <= m_cnt + 1;
    end else if (stk_pop && m_cnt > 0) begin
      m_dout <= m_mem[m_cnt-1];
      m_cnt  <= m_cnt - 1;
    end
  end

  assign stk_data_out = m_dout;
  assign stk_full     = (m_cnt == D);
  assign stk_empty    = (m_cnt == 0) || force_empty;
  assign stk_error    = tb_err;

  int n_push, n_pop, n_split;
  always_ff @(posedge clk) begin
    if (rst) begin
      if (stk_push)  n_push  <= n_push + 1;
      if (stk_pop)   n_pop   <= n_pop + 1;
      if (seg_split) n_split <= n_split + 1;
    end
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Expected output of a packet base, base+1, ... with last on the final beat.
  task automatic expect_pkt(input int n, input int base);
    exp_t e;
    int   len;
    for (int s = 0; s < n; s += D) begin
      len = (n - s < D) ? n - s : D;
      for (int j = len - 1; j >= 0; j--) begin
        e.d = DW'(base + s + j);
        e.l = (s + len == n) && (j == 0);
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_pkt(input int n, input int base, output int cycles, output bit ok);
    bit acc;
    int w;
    cycles = 0;
    ok     = 1'b1;
    for (int i = 0; i < n; i++) begin
      acc      = 1'b0;
      w        = 0;
      in_valid = 1'b1;
      in_data  = DW'(base + i);
      in_last  = (i == n - 1);
      while (!acc && w < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        w++;
        cycles++;
      end
      if (!acc) begin
        ok = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input int budget);
    exp_t e;
    int   cyc;
    cyc       = 0;
    out_ready = 1'b1;
    while (sb.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        n_total++;
        if (out_data !== e.d || out_last !== e.l)
          $display("FAIL out_beat: got data=%0d last=%0b, expected data=%0d last=%0b",
                   out_data, out_last, e.d, e.l);
        else n_pass++;
      end
    end
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_out_valid(output bit ok);
    int w;
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
        seg_split !== 1'b0 || err !== 1'b0 || stk_push !== 1'b0 || stk_pop !== 1'b0)
      $display("FAIL reset_outputs: got rdy=%0b v=%0b l=%0b d=%0d split=%0b err=%0b push=%0b pop=%0b, expected all 0",
               in_ready, out_valid, out_last, out_data, seg_split, err, stk_push, stk_pop);
    else n_pass++;
    n_total++;
    if (stk_read_more !== 1'b0) $display("FAIL read_more: got %0b expected 0", stk_read_more);
    else n_pass++;
    align();
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_reset: got %0b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    int cyc, p0;
    bit ok;
    align();
    expect_pkt(3, 1);
    p0 = n_push;
    fork
      send_pkt(3, 1, cyc, ok);
      drain(300);
    join
    @(negedge clk);
    n_total++;
    if (!ok || cyc != 3) $display("FAIL basic_accept_cycles: got %0d ok=%0b expected 3", cyc, ok);
    else n_pass++;
    n_total++;
    if (n_push - p0 != 3) $display("FAIL basic_push_count: got %0d expected 3", n_push - p0);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL basic_idle: got rdy=%0b v=%0b expected rdy=1 v=0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_split();
    int cyc, s0;
    bit ok;
    align();
    expect_pkt(7, 0);
    s0 = n_split;
    fork
      send_pkt(7, 0, cyc, ok);
      drain(400);
    join
    @(negedge clk);
    n_total++;
    if (!ok) $display("FAIL split_send: got ok=%0b expected 1", ok);
    else n_pass++;
    n_total++;
    if (n_split - s0 != 1) $display("FAIL split_pulses: got %0d expected 1", n_split - s0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int cyc, p0;
    bit ok;
    align();
    out_ready = 1'b0;
    expect_pkt(3, 1);
    send_pkt(3, 1, cyc, ok);
    wait_out_valid(ok);
    n_total++;
    if (!ok) $display("FAIL bp_valid_timeout: got out_valid=%0b expected 1", out_valid);
    else n_pass++;
    p0 = n_pop;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 3'd3)
        $display("FAIL bp_hold: got v=%0b d=%0d expected v=1 d=3", out_valid, out_data);
      else n_pass++;
    end
    n_total++;
    if (n_pop != p0) $display("FAIL bp_no_pop: got %0d pops expected 0", n_pop - p0);
    else n_pass++;
    align();
    drain(300);
  endtask

  task automatic test_error();
    int cyc;
    bit ok;
    align();
    tb_err = 1'b1;
    align();
    tb_err = 1'b0;
    @(negedge clk);
    n_total++;
    if (err !== 1'b1) $display("FAIL err_set: got %0b expected 1", err);
    else n_pass++;
    align();
    expect_pkt(2, 5);
    fork
      send_pkt(2, 5, cyc, ok);
      drain(300);
    join
    @(negedge clk);
    n_total++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %0b expected 1", err);
    else n_pass++;
  endtask

  task automatic test_reset_hold();
    int cyc;
    bit ok;
    align();
    out_ready = 1'b0;
    send_pkt(3, 1, cyc, ok);
    wait_out_valid(ok);
    n_total++;
    if (!ok || err !== 1'b1)
      $display("FAIL rh_pre: got v=%0b err=%0b expected v=1 err=1", out_valid, err);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || out_data !== '0 || err !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL rh_async: got v=%0b d=%0d err=%0b rdy=%0b expected all 0",
               out_valid, out_data, err, in_ready);
    else n_pass++;
    align();
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rh_ready: got %0b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_empty_mismatch();
    int  cyc, p0, w;
    bit  ok;
    align();
    out_ready   = 1'b1;
    force_empty = 1'b1;
    p0          = n_pop;
    send_pkt(2, 4, cyc, ok);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    n_total++;
    if (err !== 1'b1) $display("FAIL em_err: got %0b expected 1", err);
    else n_pass++;
    n_total++;
    if (n_pop != p0) $display("FAIL em_no_pop: got %0d pops expected 0", n_pop - p0);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL em_fill: got rdy=%0b v=%0b expected rdy=1 v=0", in_ready, out_valid);
    else n_pass++;
    force_empty = 1'b0;
  endtask

  initial begin
    n_push = 0; n_pop = 0; n_split = 0;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b1; force_empty = 1'b0; tb_err = 1'b0;
    test_reset();
    test_basic();
    test_split();
    test_backpressure();
    test_error();
    test_reset_hold();
    test_empty_mismatch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
